// File: rtl/adder.sv
// Registered unsigned adder: WIDTH-bit operands summed through a ripple chain of
// full-adder cells into a WIDTH+1 bit result, with carry-out and signed-overflow flags.

module adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  output logic             carry,
  output logic             sovf
);

  logic [WIDTH:0] chain;
  logic [WIDTH:0] sum;
  logic           sovf_next;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    adder_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (chain[i]),
      .s    (sum[i]),
      .cout (chain[i+1])
    );
  end

  // The final carry is kept as the MSB so the sum never wraps.
  assign sum[WIDTH] = chain[WIDTH];

  assign sovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // Data flops only load on valid input, so X operands while idle never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carry     <= 1'b0;
      sovf      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= sum;
        carry  <= sum[WIDTH];
        sovf   <= sovf_next;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the registered adder at WIDTH=4: expectations are queued
// when operands are driven and checked one cycle later when out_valid rises.

module tb_adder;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH:0] res;
    logic           c;
    logic           s;
    int             av;
    int             bv;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH:0]   result;
  logic             out_valid;
  logic             carry;
  logic             sovf;

  exp_t sb_q[$];
  int   compared;
  int   mismatched;

  adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid),
    .carry     (carry),
    .sovf      (sovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model works on integers and signed reinterpretation, not gate logic.
  function automatic exp_t model(input int av, input int bv);
    exp_t e;
    int   total;
    int   sa;
    int   sb;
    int   ssum;
    total = av + bv;
    sa    = (av >= 8) ? av - 16 : av;
    sb    = (bv >= 8) ? bv - 16 : bv;
    ssum  = sa + sb;
    e.res = total[WIDTH:0];
    e.c   = (total >= 16);
    e.s   = (ssum > 7) || (ssum < -8);
    e.av  = av;
    e.bv  = bv;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int av, input int bv);
    a        = av[WIDTH-1:0];
    b        = bv[WIDTH-1:0];
    in_valid = 1'b1;
    sb_q.push_back(model(av, bv));
  endtask

  task automatic test_reset();
    exp_t junk;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'd9;
    b        = 4'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if ({out_valid, result, carry, sovf} !== 8'b0) begin
        mismatched++;
        $display("[TB] FAIL reset%0d: got ov=%b res=%b c=%b s=%b, want all zero",
                 i, out_valid, result, carry, sovf);
      end
    end
    while (sb_q.size() > 0) junk = sb_q.pop_front();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_small();
    int pairs[3][2] = '{'{0, 0}, '{6, 1}, '{1, 0}};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(pairs[i][0], pairs[i][1]);
      step();
      in_valid = 1'b0;
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL small%0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if ({out_valid, result, carry, sovf} !== {1'b1, e.res, e.c, e.s}) begin
          mismatched++;
          $display("[TB] FAIL small %0d+%0d: got ov=%b res=%b c=%b s=%b, want ov=1 res=%b c=%b s=%b",
                   e.av, e.bv, out_valid, result, carry, sovf, e.res, e.c, e.s);
        end
      end
      step();
    end
  endtask

  task automatic test_boundaries();
    int pairs[4][2] = '{'{10, 10}, '{15, 15}, '{7, 1}, '{8, 8}};
    logic [7:0] want[4] = '{8'b1_10100_1_1, 8'b1_11110_1_0, 8'b1_01000_0_1, 8'b1_10000_1_1};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(pairs[i][0], pairs[i][1]);
      step();
      in_valid = 1'b0;
      e = sb_q.pop_front();
      compared++;
      if ({out_valid, result, carry, sovf} !== want[i] ||
          {1'b1, e.res, e.c, e.s} !== want[i]) begin
        mismatched++;
        $display("[TB] FAIL boundary %0d+%0d: got %b, want %b",
                 pairs[i][0], pairs[i][1], {out_valid, result, carry, sovf}, want[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int pairs[3][2] = '{'{3, 4}, '{5, 5}, '{15, 1}};
    int want[3] = '{7, 10, 16};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(pairs[i][0], pairs[i][1]);
      step();
      e = sb_q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || result !== e.res || int'(result) != want[i] ||
          carry !== e.c || sovf !== e.s) begin
        mismatched++;
        $display("[TB] FAIL stream%0d: got ov=%b res=%0d c=%b s=%b, want ov=1 res=%0d c=%b s=%b",
                 i, out_valid, result, carry, sovf, want[i], e.c, e.s);
      end
    end
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (out_valid !== 1'b0 || result !== 5'd16 || carry !== 1'b1 || sovf !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold%0d: got ov=%b res=%0d c=%b s=%b, want ov=0 res=16 c=1 s=0",
                 i, out_valid, result, carry, sovf);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive(5, 5);
    step();
    e = sb_q.pop_front();
    rst = 1'b1;
    a   = 4'd1;
    b   = 4'd1;
    step();
    compared++;
    if ({out_valid, result, carry, sovf} !== 8'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset: got ov=%b res=%b, want zeros", out_valid, result);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b0 || result !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL postreset_idle: got ov=%b res=%0d, want ov=0 res=0", out_valid, result);
    end
    drive(2, 3);
    step();
    in_valid = 1'b0;
    e = sb_q.pop_front();
    compared++;
    if (out_valid !== 1'b1 || result !== e.res) begin
      mismatched++;
      $display("[TB] FAIL postreset_first: got ov=%b res=%0d, want ov=1 res=%0d",
               out_valid, result, e.res);
    end
  endtask

  task automatic test_exhaustive();
    exp_t e;
    int   errs;
    errs = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        drive(x, y);
        step();
        e = sb_q.pop_front();
        compared++;
        if ({out_valid, result, carry, sovf} !== {1'b1, e.res, e.c, e.s}) begin
          mismatched++;
          errs++;
          if (errs <= 10)
            $display("[TB] FAIL exh %0d+%0d: got ov=%b res=%b c=%b s=%b, want ov=1 res=%b c=%b s=%b",
                     x, y, out_valid, result, carry, sovf, e.res, e.c, e.s);
        end
      end
    end
    in_valid = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL exh_drain: got ov=%b pending=%0d, want ov=0 pending=0",
               out_valid, sb_q.size());
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    test_reset();
    test_small();
    test_boundaries();
    test_back_to_back();
    test_reset_midstream();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
